// File: rtl/spimemio_rdseq.sv
// spimemio_rdseq: turns 32-bit memory read requests into SPI byte transactions and reassembles the reply.
// Optional continuous read (CS kept low across sequential words) is enabled by defining SPIMEMIO_CONTREAD_EN.
module spimemio_rdseq #(
  parameter logic [7:0]  CMD_SPI      = 8'h03,
  parameter logic [7:0]  CMD_QSPI     = 8'hEB,
  parameter logic [7:0]  MODE_BYTE    = 8'h20,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_qspi,
  input  logic        mem_valid,
  input  logic [23:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        xfer_resetn,
  output logic        din_valid,
  input  logic        din_ready,
  output logic [7:0]  din_data,
  output logic [3:0]  din_tag,
  output logic        din_cont,
  output logic        din_dspi,
  output logic        din_qspi,
  output logic        din_ddr,
  output logic        din_rd,
  input  logic        dout_valid,
  input  logic [7:0]  dout_data,
  input  logic [3:0]  dout_tag
);

  localparam int unsigned AW = 22;

  typedef enum logic [3:0] {
    S_IDLE, S_CSREL, S_CMD, S_A2, S_A1, S_A0, S_MODE, S_DUMMY, S_DATA, S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            quad_q, quad_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      rx_q, rx_d;
  logic            ready_d;
  logic            hs;
  logic            rx_wr;
  logic [1:0]      rx_idx;
  logic            valid_d, qspi_d, rd_d, xfer_d;
  logic [7:0]      data_d;
  logic [3:0]      tag_d;
  logic            unused_addr_lsb;

  assign din_cont        = 1'b1;
  assign din_dspi        = 1'b0;
  assign din_ddr         = 1'b0;
  assign unused_addr_lsb = ^mem_addr[1:0];

`ifdef SPIMEMIO_CONTREAD_EN
  logic          cont_q, cont_d;
  logic [AW-1:0] next_q, next_d;
  logic          seq_hit;
`endif

  // Next-state, reply collection and next-cycle transaction fields
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    quad_d  = quad_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    ready_d = 1'b0;
    hs      = din_valid && din_ready;
    rx_wr   = ((state_q == S_DATA) || (state_q == S_WAIT)) && dout_valid &&
              (dout_tag != 4'd0) && (dout_tag <= 4'd4);
    rx_idx  = 2'(dout_tag - 4'd1);
    if (rx_wr) rx_d[rx_idx] = 1'b1;
`ifdef SPIMEMIO_CONTREAD_EN
    cont_d  = cont_q;
    next_d  = next_q;
    seq_hit = cont_q && (cfg_qspi == quad_q) && (mem_addr[23:2] == next_q);
    if ((state_q == S_IDLE) && cont_q && (cfg_qspi != quad_q)) cont_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // mem_ready is still high in the first IDLE cycle while the master retires its request
        if (mem_valid && !mem_ready) begin
          addr_d  = mem_addr[23:2];
          quad_d  = cfg_qspi;
          cnt_d   = 2'd0;
          state_d = S_CSREL;
`ifdef SPIMEMIO_CONTREAD_EN
          if (seq_hit) state_d = S_DATA;
          else         cont_d  = 1'b0;
`endif
        end
      end
      S_CSREL: state_d = S_CMD;
      S_CMD:   if (hs) state_d = S_A2;
      S_A2:    if (hs) state_d = S_A1;
      S_A1:    if (hs) state_d = S_A0;
      S_A0:    if (hs) state_d = quad_q ? S_MODE : S_DATA;
      S_MODE:  if (hs) state_d = S_DUMMY;
      S_DUMMY: if (hs) state_d = S_DATA;
      S_DATA: begin
        if (hs) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rx_q == 4'hF) begin
          ready_d = 1'b1;
          rx_d    = 4'h0;
          state_d = S_IDLE;
`ifdef SPIMEMIO_CONTREAD_EN
          cont_d  = 1'b1;
          next_d  = addr_q + AW'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = 1'b0;
    data_d  = 8'h00;
    tag_d   = 4'd0;
    qspi_d  = 1'b0;
    rd_d    = 1'b0;
    case (state_d)
      S_CMD:   begin valid_d = 1'b1; data_d = quad_d ? CMD_QSPI : CMD_SPI; end
      S_A2:    begin valid_d = 1'b1; data_d = addr_d[21:14]; qspi_d = quad_d; end
      S_A1:    begin valid_d = 1'b1; data_d = addr_d[13:6]; qspi_d = quad_d; end
      S_A0:    begin valid_d = 1'b1; data_d = {addr_d[5:0], 2'b00}; qspi_d = quad_d; end
      S_MODE:  begin valid_d = 1'b1; data_d = MODE_BYTE; qspi_d = 1'b1; end
      S_DUMMY: begin valid_d = 1'b1; data_d = 8'(DUMMY_CYCLES); qspi_d = 1'b1; rd_d = 1'b1; end
      S_DATA:  begin valid_d = 1'b1; tag_d = 4'(cnt_d) + 4'd1; qspi_d = quad_d; rd_d = 1'b1; end
      default: ;
    endcase

`ifdef SPIMEMIO_CONTREAD_EN
    xfer_d = (state_d != S_CSREL) && ((state_d != S_IDLE) || cont_d);
`else
    xfer_d = (state_d != S_CSREL) && (state_d != S_IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      quad_q      <= 1'b0;
      cnt_q       <= 2'd0;
      rx_q        <= 4'h0;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'h0;
      xfer_resetn <= 1'b0;
      din_valid   <= 1'b0;
      din_data    <= 8'h00;
      din_tag     <= 4'd0;
      din_qspi    <= 1'b0;
      din_rd      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      quad_q      <= quad_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      mem_ready   <= ready_d;
      xfer_resetn <= xfer_d;
      din_valid   <= valid_d;
      din_data    <= data_d;
      din_tag     <= tag_d;
      din_qspi    <= qspi_d;
      din_rd      <= rd_d;
      if (rx_wr) mem_rdata[8*rx_idx +: 8] <= dout_data;
    end
  end

`ifdef SPIMEMIO_CONTREAD_EN
  // Continuation window: address of the word that may follow without a new command
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cont_q <= 1'b0;
      next_q <= '0;
    end else begin
      cont_q <= cont_d;
      next_q <= next_d;
    end
  end
`endif

endmodule
